// File: rtl/ros_readout_serializer.sv
// Multi-channel cycle-count readout: frames {HEADER, channel ID, count, even parity}
// are shifted out MSB first, with a clock-XOR Manchester copy on data_stream.
module ros_readout_serializer #(
   parameter int unsigned NUM_CHANNELS   = 4,
   parameter int unsigned COUNTER_LENGTH = 20,
   parameter int unsigned HEADER_LENGTH  = 4,
   parameter logic [HEADER_LENGTH-1:0] HEADER = 4'b1010,
   parameter int unsigned SYNC_STAGES    = 3,
   localparam int unsigned ID_BITS = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
   input  logic                                     clk,
   input  logic                                     reset,
   input  logic                                     ena,
   input  logic                                     send_counter,
   input  logic                                     scan_all,
   input  logic [ID_BITS-1:0]                       channel_select,
   input  logic [NUM_CHANNELS*COUNTER_LENGTH-1:0]   cycle_counts,
   output logic                                     data_stream,
   output logic                                     bit_out,
   output logic                                     busy,
   output logic                                     frame_done
);

   localparam int unsigned FRAME_LEN = HEADER_LENGTH + ID_BITS + COUNTER_LENGTH + 1;
   localparam int unsigned CNT_BITS  = $clog2(FRAME_LEN);
   localparam logic [CNT_BITS-1:0] LAST_BIT = CNT_BITS'(FRAME_LEN - 1);
   localparam logic [ID_BITS-1:0]  LAST_CH  = ID_BITS'(NUM_CHANNELS - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t                  state;
   logic [FRAME_LEN-1:0]    shreg;
   logic [CNT_BITS-1:0]     bit_cnt;
   logic [ID_BITS-1:0]      ch_idx;
   logic                    scan_mode;
   logic [SYNC_STAGES-1:0]  ena_ff;
   logic [SYNC_STAGES-1:0]  send_ff;
   logic [SYNC_STAGES-1:0]  scan_ff;
   logic                    send_prev;
   logic                    ena_sync;
   logic                    scan_sync;
   logic                    start;

   assign ena_sync  = ena_ff[SYNC_STAGES-1];
   assign scan_sync = scan_ff[SYNC_STAGES-1];
   assign start     = send_ff[SYNC_STAGES-1] & ~send_prev;

   assign bit_out     = shreg[FRAME_LEN-1];
   assign data_stream = bit_out ^ clk;

   // Channels outside NUM_CHANNELS match no loop index, so their count field stays zero.
   function automatic logic [FRAME_LEN-1:0] build_frame(
      input logic [ID_BITS-1:0]                     id,
      input logic [NUM_CHANNELS*COUNTER_LENGTH-1:0] counts
   );
      logic [COUNTER_LENGTH-1:0] cnt;
      cnt = '0;
      for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
         if (ID_BITS'(k) == id) cnt = counts[k*COUNTER_LENGTH +: COUNTER_LENGTH];
      end
      return {HEADER, id, cnt, ^{id, cnt}};
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ena_ff    <= '0;
         send_ff   <= '0;
         scan_ff   <= '0;
         send_prev <= 1'b0;
      end else begin
         ena_ff    <= {ena_ff[SYNC_STAGES-2:0], ena};
         send_ff   <= {send_ff[SYNC_STAGES-2:0], send_counter};
         scan_ff   <= {scan_ff[SYNC_STAGES-2:0], scan_all};
         send_prev <= send_ff[SYNC_STAGES-1];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         shreg      <= '0;
         bit_cnt    <= '0;
         ch_idx     <= '0;
         scan_mode  <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               shreg   <= '0;
               bit_cnt <= '0;
               ch_idx  <= '0;
               busy    <= 1'b0;
               if (start && ena_sync) begin
                  scan_mode <= scan_sync;
                  ch_idx    <= scan_sync ? '0 : channel_select;
                  shreg     <= build_frame(scan_sync ? '0 : channel_select, cycle_counts);
                  busy      <= 1'b1;
                  state     <= SHIFT;
               end
            end
            SHIFT: begin
               if (!ena_sync) begin
                  shreg   <= '0;
                  bit_cnt <= '0;
                  ch_idx  <= '0;
                  busy    <= 1'b0;
                  state   <= IDLE;
               end else if (bit_cnt == LAST_BIT) begin
                  bit_cnt <= '0;
                  // Next scan frame is loaded on the same edge so its header abuts the parity bit.
                  if (scan_mode && (ch_idx < LAST_CH)) begin
                     ch_idx <= ch_idx + 1'b1;
                     shreg  <= build_frame(ch_idx + 1'b1, cycle_counts);
                  end else begin
                     shreg      <= '0;
                     ch_idx     <= '0;
                     busy       <= 1'b0;
                     frame_done <= 1'b1;
                     state      <= IDLE;
                  end
               end else begin
                  shreg   <= {shreg[FRAME_LEN-2:0], 1'b0};
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ros_readout_serializer.sv
// Directed bench: table of single-channel frames plus scan, level-hold, abort,
// count-sampling, out-of-range and asynchronous-reset sequences.
module tb_ros_readout_serializer;

   logic        clk;
   logic        reset;
   logic        ena;
   logic        send_counter;
   logic        scan_all;
   logic [1:0]  channel_select;
   logic [79:0] cycle_counts;
   logic        data_stream, bit_out, busy, frame_done;
   logic        data_stream3, bit_out3, busy3, frame_done3;

   int unsigned total = 0;
   int unsigned bad   = 0;
   bit          use3  = 1'b0;

   logic mon_bit, mon_ds, mon_busy, mon_done;
   assign mon_bit  = use3 ? bit_out3     : bit_out;
   assign mon_ds   = use3 ? data_stream3 : data_stream;
   assign mon_busy = use3 ? busy3        : busy;
   assign mon_done = use3 ? frame_done3  : frame_done;

   ros_readout_serializer #(.NUM_CHANNELS(4), .COUNTER_LENGTH(20)) dut (
      .clk(clk), .reset(reset), .ena(ena), .send_counter(send_counter),
      .scan_all(scan_all), .channel_select(channel_select), .cycle_counts(cycle_counts),
      .data_stream(data_stream), .bit_out(bit_out), .busy(busy), .frame_done(frame_done));

   ros_readout_serializer #(.NUM_CHANNELS(3), .COUNTER_LENGTH(20)) dut3 (
      .clk(clk), .reset(reset), .ena(ena), .send_counter(send_counter),
      .scan_all(scan_all), .channel_select(channel_select), .cycle_counts(cycle_counts[59:0]),
      .data_stream(data_stream3), .bit_out(bit_out3), .busy(busy3), .frame_done(frame_done3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endfunction

   // Waits (bounded) for busy, then samples nbits bits at successive falling edges.
   task automatic capture(input string name, input int unsigned nbits, input int poke_at,
                          input int poke_kind, output logic [127:0] bits,
                          output logic [127:0] ds, output int unsigned busy_cnt,
                          output int unsigned done_cnt);
      bit found;
      found = 1'b0; bits = '0; ds = '0; busy_cnt = 0; done_cnt = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (mon_busy) found = 1'b1;
      end
      if (!found) begin
         check({name, "_start"}, 128'd0, 128'd1);
      end else begin
         for (int i = 0; i < int'(nbits); i++) begin
            bits = {bits[126:0], mon_bit};
            ds   = {ds[126:0], mon_ds};
            if (mon_busy) busy_cnt++;
            if (mon_done) done_cnt++;
            if (i == poke_at && poke_kind == 1) cycle_counts[19:0] = 20'd9;
            if (i == poke_at && poke_kind == 2) send_counter = 1'b0;
            if (i == poke_at + 3 && poke_kind == 2) send_counter = 1'b1;
            if (i == poke_at + 6 && poke_kind == 2) send_counter = 1'b0;
            if (i == poke_at && poke_kind == 4) scan_all = 1'b0;
            if (i < int'(nbits) - 1) @(negedge clk);
         end
      end
   endtask

   task automatic single_frame(input string name, input logic [1:0] sel, input logic [26:0] exp,
                               input int poke_at, input int poke_kind);
      logic [127:0] bits, ds;
      int unsigned  bc, dc;
      repeat (6) @(negedge clk);
      channel_select = sel;
      send_counter   = 1'b1;
      capture(name, 27, poke_at, poke_kind, bits, ds, bc, dc);
      send_counter = 1'b0;
      check({name, "_bits"}, bits[26:0], {101'd0, exp});
      check({name, "_ds"}, ds[26:0], {101'd0, exp});
      @(negedge clk);
      check({name, "_done"}, {mon_done, mon_busy, mon_bit}, 128'b100);
      @(negedge clk);
      check({name, "_done_clr"}, mon_done, 128'd0);
   endtask

   typedef struct {
      logic [1:0]  sel;
      logic [19:0] cnt;
      logic [26:0] exp;
   } vec_t;

   vec_t vecs[6];

   initial begin
      logic [127:0] bits, ds;
      logic [26:0]  fexp;
      int unsigned  bc, dc, rises, dones;
      logic         prev_busy;

      vecs[0] = '{2'd2, 20'hABCDE, {4'b1010, 2'd2, 20'hABCDE, 1'b0}};
      vecs[1] = '{2'd0, 20'h00001, {4'b1010, 2'd0, 20'h00001, 1'b1}};
      vecs[2] = '{2'd1, 20'hFFFFF, {4'b1010, 2'd1, 20'hFFFFF, 1'b1}};
      vecs[3] = '{2'd3, 20'h00000, {4'b1010, 2'd3, 20'h00000, 1'b0}};
      vecs[4] = '{2'd3, 20'h80001, {4'b1010, 2'd3, 20'h80001, 1'b0}};
      vecs[5] = '{2'd2, 20'h00003, {4'b1010, 2'd2, 20'h00003, 1'b1}};

      reset = 1'b1; ena = 1'b0; send_counter = 1'b0; scan_all = 1'b0;
      channel_select = 2'd0; cycle_counts = '0;
      #2;
      check("reset_lo", {bit_out, busy, frame_done, data_stream}, 128'd0);
      @(posedge clk); #2;
      check("reset_hi", {bit_out, busy, frame_done, data_stream}, 128'b0001);
      @(negedge clk); reset = 1'b0; ena = 1'b1;
      repeat (6) @(negedge clk);
      check("idle", {bit_out, busy, frame_done}, 128'd0);

      for (int v = 0; v < 6; v++) begin
         for (int k = 0; k < 4; k++)
            cycle_counts[k*20 +: 20] = (k == int'(vecs[v].sel)) ? vecs[v].cnt : 20'h5A5A0 + 20'(k);
         single_frame($sformatf("vec%0d", v), vecs[v].sel, vecs[v].exp, -1, 0);
      end

      // scan with mode dropped mid-scan
      cycle_counts = {20'd4, 20'd3, 20'd2, 20'd1};
      channel_select = 2'd2; scan_all = 1'b1;
      repeat (6) @(negedge clk);
      send_counter = 1'b1;
      capture("scan", 108, 30, 4, bits, ds, bc, dc);
      send_counter = 1'b0;
      check("scan_f0", bits[107:81], {101'd0, 4'b1010, 2'd0, 20'd1, 1'b1});
      check("scan_f1", bits[80:54],  {101'd0, 4'b1010, 2'd1, 20'd2, 1'b0});
      check("scan_f2", bits[53:27],  {101'd0, 4'b1010, 2'd2, 20'd3, 1'b1});
      check("scan_f3", bits[26:0],   {101'd0, 4'b1010, 2'd3, 20'd4, 1'b1});
      check("scan_busy", bc, 128'd108);
      check("scan_early_done", dc, 128'd0);
      @(negedge clk);
      check("scan_done", {frame_done, busy}, 128'b10);
      dones = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (frame_done) dones++;
      end
      check("scan_one_done", dones, 128'd0);

      // level held high for 200 cycles
      scan_all = 1'b0; channel_select = 2'd1;
      send_counter = 1'b1; rises = 0; dones = 0; prev_busy = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (busy && !prev_busy) rises++;
         if (frame_done) dones++;
         prev_busy = busy;
      end
      send_counter = 1'b0;
      check("level_frames", rises, 128'd1);
      check("level_dones", dones, 128'd1);

      // second request pulsed mid-frame is ignored
      cycle_counts = {20'd4, 20'hABCDE, 20'd2, 20'd1};
      single_frame("ignore", 2'd2, {4'b1010, 2'd2, 20'hABCDE, 1'b0}, 8, 2);
      bc = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (busy) bc++;
      end
      check("ignore_nobusy", bc, 128'd0);

      // count sampled at load edge
      cycle_counts[19:0] = 20'd5;
      single_frame("sample", 2'd0, {4'b1010, 2'd0, 20'd5, 1'b0}, 5, 1);

      // abort by dropping ena at bit 10
      cycle_counts[59:40] = 20'hABCDE;
      repeat (6) @(negedge clk);
      channel_select = 2'd2; send_counter = 1'b1;
      capture("abort", 10, -1, 0, bits, ds, bc, dc);
      send_counter = 1'b0;
      check("abort_prefix", bits[9:0], {118'd0, 10'b1010_10_1010});
      @(negedge clk);
      ena = 1'b0;
      dones = 0;
      repeat (4) begin
         @(negedge clk);
         if (frame_done) dones++;
      end
      check("abort_idle", {busy, bit_out}, 128'd0);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (frame_done) dones++;
      end
      check("abort_nodone", dones, 128'd0);
      ena = 1'b1;
      single_frame("after_abort", 2'd2, {4'b1010, 2'd2, 20'hABCDE, 1'b0}, -1, 0);

      // out-of-range channel on the 3-channel instance
      use3 = 1'b1;
      cycle_counts = {20'hFFFFF, 20'h12345, 20'h54321, 20'h11111};
      single_frame("oor", 2'd3, {4'b1010, 2'd3, 20'd0, 1'b0}, -1, 0);
      use3 = 1'b0;

      // asynchronous reset mid-scan
      scan_all = 1'b1;
      repeat (6) @(negedge clk);
      send_counter = 1'b1;
      capture("rst_scan", 20, -1, 0, bits, ds, bc, dc);
      send_counter = 1'b0;
      repeat (20) @(negedge clk);
      check("rst_pre_busy", busy, 128'd1);
      @(posedge clk); #2;
      reset = 1'b1;
      #1;
      check("rst_async", {bit_out, busy, frame_done, data_stream}, 128'b0001);
      @(negedge clk);
      reset = 1'b0;
      bc = 0;
      for (int i = 0; i < 150; i++) begin
         @(negedge clk);
         if (busy || frame_done || bit_out) bc++;
      end
      check("rst_no_resume", bc, 128'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
